// File: rtl/fpm_pipe_stage.sv
// fpm_pipe_stage
//   Elastic pipeline stage between the multiply and normalise steps of the
//   vector floating-point multiplier. Each beat carries per-lane sign, biased
//   exponent (with overflow bit) and raw mantissa product. A valid/ready
//   handshake with a 2-entry skid buffer decouples in_ready from out_ready.
//   Lanes whose mask bit is clear are stored as all-zero. A synchronous flush
//   discards everything held.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous flush, overrides every other event in its cycle
//   in_valid   upstream beat valid
//   in_ready   stage can take a beat (decoded from state only)
//   in_mask    per-lane enable, bit i = lane i
//   in_sign    per-lane sign
//   in_exp     lane i at [i*EXP_W +: EXP_W]
//   in_prod    lane i at [i*PROD_W +: PROD_W]
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_mask / out_sign / out_exp / out_prod   registered head-of-stage beat
module fpm_pipe_stage #(
  parameter int LANES  = 4,
  parameter int EXP_W  = 9,
  parameter int PROD_W = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES-1:0]        in_sign,
  input  logic [LANES*EXP_W-1:0]  in_exp,
  input  logic [LANES*PROD_W-1:0] in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES-1:0]        out_sign,
  output logic [LANES*EXP_W-1:0]  out_exp,
  output logic [LANES*PROD_W-1:0] out_prod
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic accept;
  logic drain;

  logic [LANES-1:0]        m_sign;
  logic [LANES*EXP_W-1:0]  m_exp;
  logic [LANES*PROD_W-1:0] m_prod;

  logic [LANES-1:0]        skid_mask;
  logic [LANES-1:0]        skid_sign;
  logic [LANES*EXP_W-1:0]  skid_exp;
  logic [LANES*PROD_W-1:0] skid_prod;

  // Handshake flags come straight from the state register so that in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  // Disabled lanes are zeroed before storage; the mask bit itself is kept.
  always_comb begin
    m_sign = '0;
    m_exp  = '0;
    m_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_mask[i]) begin
        m_sign[i]                   = in_sign[i];
        m_exp[i*EXP_W +: EXP_W]     = in_exp[i*EXP_W +: EXP_W];
        m_prod[i*PROD_W +: PROD_W]  = in_prod[i*PROD_W +: PROD_W];
      end
    end
  end

  // Next-state and register-load decode. Flush wins over accept and drain:
  // nothing is loaded and the stage returns to EMPTY.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main register drives the outputs; it only changes on a load, so outputs
  // stay stable while the downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_mask <= '0;
      out_sign <= '0;
      out_exp  <= '0;
      out_prod <= '0;
    end else if (load_main_in) begin
      out_mask <= in_mask;
      out_sign <= m_sign;
      out_exp  <= m_exp;
      out_prod <= m_prod;
    end else if (load_main_skid) begin
      out_mask <= skid_mask;
      out_sign <= skid_sign;
      out_exp  <= skid_exp;
      out_prod <= skid_prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_mask <= '0;
      skid_sign <= '0;
      skid_exp  <= '0;
      skid_prod <= '0;
    end else if (load_skid) begin
      skid_mask <= in_mask;
      skid_sign <= m_sign;
      skid_exp  <= m_exp;
      skid_prod <= m_prod;
    end
  end

endmodule

// File: tb/tb_fpm_pipe_stage.sv
// tb_fpm_pipe_stage
//   Self-checking bench for fpm_pipe_stage. A queue of at most two beats is
//   the reference: it models what the stage holds, and its head is what the
//   outputs must show whenever out_valid is high.
module tb_fpm_pipe_stage;

  localparam int LANES  = 4;
  localparam int EXP_W  = 9;
  localparam int PROD_W = 48;

  typedef struct packed {
    logic [LANES-1:0]        mask;
    logic [LANES-1:0]        sign;
    logic [LANES*EXP_W-1:0]  exp;
    logic [LANES*PROD_W-1:0] prod;
  } beat_t;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_mask;
  logic [LANES-1:0]        in_sign;
  logic [LANES*EXP_W-1:0]  in_exp;
  logic [LANES*PROD_W-1:0] in_prod;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_mask;
  logic [LANES-1:0]        out_sign;
  logic [LANES*EXP_W-1:0]  out_exp;
  logic [LANES*PROD_W-1:0] out_prod;

  int errors = 0;
  int checks = 0;

  beat_t held[$];

  fpm_pipe_stage #(.LANES(LANES), .EXP_W(EXP_W), .PROD_W(PROD_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mask(in_mask),
    .in_sign(in_sign),
    .in_exp(in_exp),
    .in_prod(in_prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mask(out_mask),
    .out_sign(out_sign),
    .out_exp(out_exp),
    .out_prod(out_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mask_beat(input beat_t b);
    beat_t r;
    r = '0;
    r.mask = b.mask;
    for (int i = 0; i < LANES; i++) begin
      if (b.mask[i]) begin
        r.sign[i]                  = b.sign[i];
        r.exp[i*EXP_W +: EXP_W]    = b.exp[i*EXP_W +: EXP_W];
        r.prod[i*PROD_W +: PROD_W] = b.prod[i*PROD_W +: PROD_W];
      end
    end
    return r;
  endfunction

  function automatic beat_t random_beat();
    beat_t b;
    b.mask = 4'($urandom);
    b.sign = 4'($urandom);
    b.exp  = 36'({$urandom, $urandom});
    b.prod = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  task automatic apply_stimulus(input logic v, input beat_t b);
    in_valid = v;
    in_mask  = b.mask;
    in_sign  = b.sign;
    in_exp   = b.exp;
    in_prod  = b.prod;
  endtask

  task automatic compare_state(input string tag);
    beat_t obs;
    obs = {out_mask, out_sign, out_exp, out_prod};
    check_output({tag, "_valid"}, 256'(out_valid), 256'(held.size() > 0));
    check_output({tag, "_ready"}, 256'(in_ready), 256'(held.size() < 2));
    if (held.size() > 0) check_output({tag, "_data"}, 256'(obs), 256'(held[0]));
  endtask

  // One clock: predict handshake from the model, advance, then compare.
  task automatic cycle(input string tag, output bit accepted);
    bit acc, drn;
    beat_t cur;
    cur = {in_mask, in_sign, in_exp, in_prod};
    acc = in_valid && (held.size() < 2) && !flush;
    drn = (held.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      held.delete();
    end else begin
      if (drn) void'(held.pop_front());
      if (acc) held.push_back(mask_beat(cur));
    end
    #1;
    compare_state(tag);
    accepted = acc;
  endtask

  initial begin
    bit    acc;
    beat_t b;
    beat_t zero;
    zero = '0;

    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    apply_stimulus(1'b0, zero);

    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_valid", 256'(out_valid), 256'(0));
    check_output("rst_ready", 256'(in_ready), 256'(1));
    check_output("rst_data", 256'({out_mask, out_sign, out_exp, out_prod}), 256'(0));
    reset = 1'b1;
    cycle("idle", acc);

    // Streaming with out_ready held high: no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = random_beat();
      b.mask = 4'hF;
      b.exp[8:0]  = 9'(9'h07F + i);
      b.prod[47:0] = 48'(i + 1);
      apply_stimulus(1'b1, b);
      cycle("stream", acc);
      check_output("stream_acc", 256'(acc), 256'(1));
      check_output("stream_out_valid", 256'(out_valid), 256'(1));
    end
    apply_stimulus(1'b0, zero);
    cycle("stream_tail", acc);

    // Backpressure into the skid buffer
    out_ready = 1'b0;
    b = random_beat();
    b.exp[8:0] = 9'h100;
    apply_stimulus(1'b1, b);
    cycle("bp_a", acc);
    b = random_beat();
    b.exp[8:0] = 9'h101;
    apply_stimulus(1'b1, b);
    cycle("bp_b", acc);
    check_output("bp_full_ready", 256'(in_ready), 256'(0));
    b = random_beat();
    b.exp[8:0] = 9'h102;
    apply_stimulus(1'b1, b);
    repeat (2) cycle("bp_c_held", acc);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cycle("bp_c_wait", acc);
    check_output("bp_c_accepted", 256'(acc), 256'(1));
    apply_stimulus(1'b0, zero);
    repeat (4) cycle("bp_drain", acc);

    // Masking
    b.mask = 4'b0101;
    b.sign = 4'hF;
    b.exp  = {4{9'h1FF}};
    b.prod = {4{48'hFFFF_FFFF_FFFF}};
    apply_stimulus(1'b1, b);
    cycle("mask", acc);
    check_output("mask_lanes", 256'({out_mask, out_sign, out_exp, out_prod}),
                 256'({4'b0101, 4'b0101, 9'h0, 9'h1FF, 9'h0, 9'h1FF,
                       48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 48'hFFFF_FFFF_FFFF}));
    apply_stimulus(1'b0, zero);
    cycle("mask_drain", acc);

    // Flush while FULL, together with a new beat and out_ready
    out_ready = 1'b0;
    repeat (2) begin
      apply_stimulus(1'b1, random_beat());
      cycle("fl_fill", acc);
    end
    check_output("fl_is_full", 256'(in_ready), 256'(0));
    flush     = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b1, random_beat());
    cycle("fl_flush", acc);
    check_output("fl_valid", 256'(out_valid), 256'(0));
    check_output("fl_ready", 256'(in_ready), 256'(1));
    flush = 1'b0;
    apply_stimulus(1'b0, zero);
    repeat (3) begin
      cycle("fl_after", acc);
      check_output("fl_no_emit", 256'(out_valid), 256'(0));
    end

    // Async reset while FULL
    out_ready = 1'b0;
    repeat (2) begin
      apply_stimulus(1'b1, random_beat());
      cycle("ar_fill", acc);
    end
    apply_stimulus(1'b0, zero);
    @(negedge clk);
    reset = 1'b0;
    held.delete();
    #1;
    check_output("ar_valid", 256'(out_valid), 256'(0));
    check_output("ar_ready", 256'(in_ready), 256'(1));
    check_output("ar_data", 256'({out_mask, out_sign, out_exp, out_prod}), 256'(0));
    #2;
    reset = 1'b1;
    out_ready = 1'b1;
    b = random_beat();
    b.mask = 4'hF;
    apply_stimulus(1'b1, b);
    cycle("ar_d", acc);
    check_output("ar_d_data", 256'({out_mask, out_sign, out_exp, out_prod}), 256'(b));
    apply_stimulus(1'b0, zero);
    cycle("ar_d_drain", acc);

    // Randomised traffic including zero-mask beats and occasional flush
    for (int n = 0; n < 400; n++) begin
      b = random_beat();
      if ($urandom_range(0, 7) == 0) b.mask = '0;
      apply_stimulus(1'($urandom_range(0, 3) != 0), b);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle("rand", acc);
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
